// File: rtl/card_dealer.sv
// rtl/card_dealer.sv - unique-card dealer for a single 52-card deck
//
// Purpose: draws cards without replacement. The deck start index comes from a
// free-running counter value sampled when the draw is accepted. Occupied
// slots are skipped by linear probing, one probe per clock.
//
// Ports:
//   clk_50M      in   system clock, all state on posedge
//   i_Reset_n    in   asynchronous active-low reset
//   i_Seed       in   counter value; only [5:0] selects the start index
//   i_Draw       in   draw request, sampled only while idle
//   i_Shuffle    in   return every card to the deck (aborts a search)
//   o_Card       out  rank 1..13 (0 before the first deal)
//   o_Suit       out  suit 0..3
//   o_Value      out  points: A=1, 2..10 face value, J/Q/K=10
//   o_Valid      out  one-cycle pulse when card outputs update
//   o_Busy       out  high while probing
//   o_Empty      out  high when no cards remain
//   o_Remaining  out  undealt card count 0..52
module card_dealer #(
    parameter int WIDTH     = 12,
    parameter int DECK_SIZE = 52
) (
    input  logic             clk_50M,
    input  logic             i_Reset_n,
    input  logic [WIDTH-1:0] i_Seed,
    input  logic             i_Draw,
    input  logic             i_Shuffle,
    output logic [3:0]       o_Card,
    output logic [1:0]       o_Suit,
    output logic [3:0]       o_Value,
    output logic             o_Valid,
    output logic             o_Busy,
    output logic             o_Empty,
    output logic [5:0]       o_Remaining
);

    typedef enum logic {
        S_IDLE,
        S_SEARCH
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(DECK_SIZE - 1);
    localparam logic [5:0] FULL_CNT = 6'(DECK_SIZE);

    state_t               state_q, state_d;
    logic [DECK_SIZE-1:0] used_q, used_d;
    logic [5:0]           idx_q, idx_d;
    logic [5:0]           remaining_q, remaining_d;
    logic [3:0]           card_q, card_d;
    logic [1:0]           suit_q, suit_d;
    logic [3:0]           value_q, value_d;
    logic                 valid_q, valid_d;

    logic [5:0]           seed_idx;
    logic [1:0]           hit_suit;
    logic [3:0]           hit_off;
    logic [3:0]           hit_rank;
    logic                 unused_seed_bits;

    // Upper counter bits carry no extra entropy for a 52-entry deck.
    assign unused_seed_bits = ^i_Seed[WIDTH-1:6];

    // Fold 0..63 into 0..51 with a single conditional subtract.
    assign seed_idx = (i_Seed[5:0] >= FULL_CNT) ? (i_Seed[5:0] - FULL_CNT) : i_Seed[5:0];

    // idx/13 and idx%13 by range compare: cheaper than a divider for 52 slots.
    always_comb begin
        if (idx_q >= 6'd39) begin
            hit_suit = 2'd3;
            hit_off  = 4'(idx_q - 6'd39);
        end else if (idx_q >= 6'd26) begin
            hit_suit = 2'd2;
            hit_off  = 4'(idx_q - 6'd26);
        end else if (idx_q >= 6'd13) begin
            hit_suit = 2'd1;
            hit_off  = 4'(idx_q - 6'd13);
        end else begin
            hit_suit = 2'd0;
            hit_off  = idx_q[3:0];
        end
    end

    assign hit_rank = hit_off + 4'd1;

    always_comb begin
        state_d     = state_q;
        used_d      = used_q;
        idx_d       = idx_q;
        remaining_d = remaining_q;
        card_d      = card_q;
        suit_d      = suit_q;
        value_d     = value_q;
        valid_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Shuffle wins over a coincident draw; the draw is dropped.
                if (i_Shuffle) begin
                    used_d      = '0;
                    remaining_d = FULL_CNT;
                end else if (i_Draw && !o_Empty) begin
                    idx_d   = seed_idx;
                    state_d = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (i_Shuffle) begin
                    used_d      = '0;
                    remaining_d = FULL_CNT;
                    state_d     = S_IDLE;
                end else if (used_q[idx_q]) begin
                    idx_d = (idx_q == LAST_IDX) ? 6'd0 : idx_q + 6'd1;
                end else begin
                    used_d[idx_q] = 1'b1;
                    remaining_d   = remaining_q - 6'd1;
                    card_d        = hit_rank;
                    suit_d        = hit_suit;
                    value_d       = (hit_rank >= 4'd10) ? 4'd10 : hit_rank;
                    valid_d       = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q     <= S_IDLE;
            used_q      <= '0;
            idx_q       <= '0;
            remaining_q <= FULL_CNT;
            card_q      <= '0;
            suit_q      <= '0;
            value_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            used_q      <= used_d;
            idx_q       <= idx_d;
            remaining_q <= remaining_d;
            card_q      <= card_d;
            suit_q      <= suit_d;
            value_q     <= value_d;
            valid_q     <= valid_d;
        end
    end

    assign o_Card      = card_q;
    assign o_Suit      = suit_q;
    assign o_Value     = value_q;
    assign o_Valid     = valid_q;
    assign o_Busy      = (state_q == S_SEARCH);
    assign o_Empty     = (remaining_q == 6'd0);
    assign o_Remaining = remaining_q;

endmodule

// File: tb/tb_card_dealer.sv
// tb/tb_card_dealer.sv - self-checking bench for card_dealer
module tb_card_dealer;

    logic        clk_50M = 1'b0;
    logic        i_Reset_n;
    logic [11:0] i_Seed;
    logic        i_Draw;
    logic        i_Shuffle;
    logic [3:0]  o_Card;
    logic [1:0]  o_Suit;
    logic [3:0]  o_Value;
    logic        o_Valid;
    logic        o_Busy;
    logic        o_Empty;
    logic [5:0]  o_Remaining;

    int total = 0;
    int bad   = 0;

    // Reference deck: plain array of dealt flags plus remembered last deal.
    bit used[52];
    int remaining;
    int last_card, last_suit, last_value;
    bit seen[4][14];

    always #10 clk_50M = ~clk_50M;

    card_dealer #(.WIDTH(12), .DECK_SIZE(52)) dut (
        .clk_50M    (clk_50M),
        .i_Reset_n  (i_Reset_n),
        .i_Seed     (i_Seed),
        .i_Draw     (i_Draw),
        .i_Shuffle  (i_Shuffle),
        .o_Card     (o_Card),
        .o_Suit     (o_Suit),
        .o_Value    (o_Value),
        .o_Valid    (o_Valid),
        .o_Busy     (o_Busy),
        .o_Empty    (o_Empty),
        .o_Remaining(o_Remaining)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        foreach (used[i]) used[i] = 1'b0;
        remaining = 52;
    endtask

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_remaining"}, o_Remaining, remaining);
        check({tag, "_empty"}, o_Empty, remaining == 0);
        check({tag, "_busy"}, o_Busy, 0);
        check({tag, "_card"}, o_Card, last_card);
        check({tag, "_suit"}, o_Suit, last_suit);
        check({tag, "_value"}, o_Value, last_value);
    endtask

    // Issue one draw and compare against the reference deck.
    task automatic do_draw(input string tag, input logic [11:0] seed);
        int start, idx, k, lat, rank;
        bit exp_hit, got;
        start   = int'(seed) % 64;
        if (start >= 52) start -= 52;
        exp_hit = (remaining > 0);
        idx     = start;
        k       = 0;
        if (exp_hit) begin
            while (used[idx]) begin
                idx = (idx + 1) % 52;
                k++;
            end
        end
        i_Seed = seed;
        i_Draw = 1'b1;
        tick();
        i_Draw = 1'b0;
        check({tag, "_busy_accept"}, o_Busy, exp_hit);
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= (exp_hit ? 60 : 6); c++) begin
            tick();
            if (o_Valid) begin
                got = 1'b1;
                lat = c;
                break;
            end
        end
        check({tag, "_valid_seen"}, got, exp_hit);
        if (exp_hit && got) begin
            rank       = idx % 13 + 1;
            last_card  = rank;
            last_suit  = idx / 13;
            last_value = (rank > 10) ? 10 : rank;
            used[idx]  = 1'b1;
            remaining--;
            check({tag, "_latency"}, lat, k + 1);
            check({tag, "_card"}, o_Card, last_card);
            check({tag, "_suit"}, o_Suit, last_suit);
            check({tag, "_value"}, o_Value, last_value);
            check({tag, "_remaining"}, o_Remaining, remaining);
            tick();
            check({tag, "_valid_pulse"}, o_Valid, 0);
        end
    endtask

    task automatic do_shuffle();
        i_Shuffle = 1'b1;
        tick();
        i_Shuffle = 1'b0;
        model_clear();
    endtask

    initial begin
        bit got;
        logic [11:0] s;

        i_Reset_n = 1'b0;
        i_Seed    = '0;
        i_Draw    = 1'b0;
        i_Shuffle = 1'b0;
        model_clear();
        last_card = 0; last_suit = 0; last_value = 0;
        tick();
        tick();
        check("rst_valid", o_Valid, 0);
        check_idle("rst");
        i_Reset_n = 1'b1;
        tick();

        // First deal, repeat seed probes forward, and seed folding 63 -> 11.
        do_draw("seed0", 12'h000);
        do_draw("seed0_again", 12'h000);
        do_draw("seed3f", 12'h03F);

        // Shuffle with a coincident draw: draw dropped, outputs kept.
        i_Seed    = 12'h005;
        i_Draw    = 1'b1;
        i_Shuffle = 1'b1;
        tick();
        i_Draw    = 1'b0;
        i_Shuffle = 1'b0;
        model_clear();
        check_idle("shuf_draw");
        tick();
        check("shuf_draw_valid", o_Valid, 0);

        // Wrap from index 51 to 0.
        do_draw("idx51", 12'h033);
        do_draw("wrap", 12'h033);

        // Full deck with random seeds.
        do_shuffle();
        foreach (seen[i, j]) seen[i][j] = 1'b0;
        for (int n = 0; n < 52; n++) begin
            s = 12'($urandom);
            do_draw("rand", s);
            check("distinct", seen[o_Suit][o_Card], 0);
            seen[o_Suit][o_Card] = 1'b1;
        end
        check_idle("full");
        do_draw("empty_draw", 12'($urandom));
        check_idle("empty_after");
        do_shuffle();
        check_idle("reshuffle");

        // Reset in the middle of a long search.
        for (int n = 0; n < 40; n++) do_draw("fill_a", 12'(n));
        i_Seed = 12'h000;
        i_Draw = 1'b1;
        tick();
        i_Draw = 1'b0;
        tick();
        tick();
        i_Reset_n = 1'b0;
        #2;
        model_clear();
        last_card = 0; last_suit = 0; last_value = 0;
        check("rst_mid_valid", o_Valid, 0);
        check_idle("rst_mid");
        tick();
        i_Reset_n = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (o_Valid) got = 1'b1;
        end
        check("rst_mid_no_valid", got, 0);

        // Shuffle one cycle into a long search.
        for (int n = 0; n < 40; n++) do_draw("fill_b", 12'(n));
        i_Seed = 12'h000;
        i_Draw = 1'b1;
        tick();
        i_Draw    = 1'b0;
        i_Shuffle = 1'b1;
        tick();
        i_Shuffle = 1'b0;
        model_clear();
        got = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (o_Valid) got = 1'b1;
            tick();
        end
        check("abort_no_valid", got, 0);
        check_idle("abort");
        do_draw("after_abort", 12'h00A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
